sensor_alarm_ctrl: RTL and testbench

- Parametrised multi-channel sensor-to-buzzer alarm controller.
- Debounces NUM_CH sensor inputs with a fixed-priority arbiter, then drives a one-hot buzzer for the winning channel.
- Buzzer mode is either timed or latched-until-acknowledge; a cooldown window follows every alarm.
- Keeps a saturating count of alarm events. Sits between the ui sensor pins and the uo buzzer pins of the top level.

---
 rtl/sensor_alarm_ctrl.sv | 144 ++++++++++++++
 tb/tb_sensor_alarm_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_alarm_ctrl.sv
// Multi-channel sensor alarm controller: fixed-priority debounce, one-hot buzzer
// drive in timed or latched mode, post-alarm cooldown and a saturating event counter.
module sensor_alarm_ctrl #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DEBOUNCE  = 8,
  parameter int unsigned ALARM_LEN = 32,
  parameter int unsigned COOLDOWN  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NUM_CH-1:0]         sensor,
  input  logic                      mode_latch,
  input  logic                      ack,
  input  logic                      clr_cnt,
  output logic [NUM_CH-1:0]         buzzer,
  output logic [$clog2(NUM_CH)-1:0] active_ch,
  output logic                      alarm_active,
  output logic [7:0]                event_cnt
);

  localparam int unsigned ChW = $clog2(NUM_CH);

  typedef enum logic [1:0] {StIdle, StQualify, StAlarm, StCooldown} state_e;

  state_e             state_q, state_d;
  logic [7:0]         qcnt_q, qcnt_d;
  logic [15:0]        acnt_q, acnt_d;
  logic [7:0]         ccnt_q, ccnt_d;
  logic [ChW-1:0]     active_ch_q, active_ch_d;
  logic               mode_q, mode_d;
  logic [NUM_CH-1:0]  buzzer_q, buzzer_d;
  logic               alarm_active_q, alarm_active_d;
  logic [7:0]         event_cnt_q, event_cnt_d;

  logic               win_valid;
  logic [ChW-1:0]     win_idx;
  logic               alarm_enter, alarm_exit;

  // Scan from the top so the lowest asserted index is the one left standing.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (sensor[i]) begin
        win_valid = 1'b1;
        win_idx   = ChW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      qcnt_q         <= '0;
      acnt_q         <= '0;
      ccnt_q         <= '0;
      active_ch_q    <= '0;
      mode_q         <= 1'b0;
      buzzer_q       <= '0;
      alarm_active_q <= 1'b0;
      event_cnt_q    <= '0;
    end else if (ena) begin
      state_q        <= state_d;
      qcnt_q         <= qcnt_d;
      acnt_q         <= acnt_d;
      ccnt_q         <= ccnt_d;
      active_ch_q    <= active_ch_d;
      mode_q         <= mode_d;
      buzzer_q       <= buzzer_d;
      alarm_active_q <= alarm_active_d;
      event_cnt_q    <= event_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    acnt_d      = acnt_q;
    ccnt_d      = ccnt_q;
    active_ch_d = active_ch_q;
    mode_d      = mode_q;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          active_ch_d = win_idx;
          qcnt_d      = 8'd1;
          state_d     = StQualify;
        end
      end
      StQualify: begin
        if (!win_valid) begin
          qcnt_d  = '0;
          state_d = StIdle;
        end else if (win_idx != active_ch_q) begin
          active_ch_d = win_idx;
          qcnt_d      = 8'd1;
        end else if (qcnt_q == 8'(DEBOUNCE - 1)) begin
          acnt_d  = '0;
          mode_d  = mode_latch;
          state_d = StAlarm;
        end else begin
          qcnt_d = qcnt_q + 8'd1;
        end
      end
      StAlarm: begin
        if (acnt_q != '1) acnt_d = acnt_q + 16'd1;
        if (ack || (!mode_q && acnt_q == 16'(ALARM_LEN - 1))) begin
          ccnt_d  = '0;
          state_d = StCooldown;
        end
      end
      StCooldown: begin
        if (ccnt_q == 8'(COOLDOWN - 1)) state_d = StIdle;
        else                            ccnt_d  = ccnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign alarm_enter = (state_q == StQualify) && (state_d == StAlarm);
  assign alarm_exit  = (state_q == StAlarm) && (state_d == StCooldown);

  always_comb begin
    buzzer_d       = buzzer_q;
    alarm_active_d = alarm_active_q;
    event_cnt_d    = event_cnt_q;
    if (alarm_enter) begin
      for (int i = 0; i < int'(NUM_CH); i++) buzzer_d[i] = (active_ch_q == ChW'(i));
      alarm_active_d = 1'b1;
    end else if (alarm_exit) begin
      buzzer_d       = '0;
      alarm_active_d = 1'b0;
    end
    if (clr_cnt)                                event_cnt_d = '0;
    else if (alarm_enter && event_cnt_q != '1)  event_cnt_d = event_cnt_q + 8'd1;
  end

  assign buzzer       = buzzer_q;
  assign active_ch    = active_ch_q;
  assign alarm_active = alarm_active_q;
  assign event_cnt    = event_cnt_q;

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Directed bench for sensor_alarm_ctrl with NUM_CH=4, DEBOUNCE=8, ALARM_LEN=32, COOLDOWN=4.
module tb_sensor_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] sensor;
  logic       mode_latch;
  logic       ack;
  logic       clr_cnt;
  logic [3:0] buzzer;
  logic [1:0] active_ch;
  logic       alarm_active;
  logic [7:0] event_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  sensor_alarm_ctrl #(
    .NUM_CH   (4),
    .DEBOUNCE (8),
    .ALARM_LEN(32),
    .COOLDOWN (4)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .sensor      (sensor),
    .mode_latch  (mode_latch),
    .ack         (ack),
    .clr_cnt     (clr_cnt),
    .buzzer      (buzzer),
    .active_ch   (active_ch),
    .alarm_active(alarm_active),
    .event_cnt   (event_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n active edges; leaves time 1 unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    ena        = 1'b1;
    sensor     = '0;
    mode_latch = 1'b0;
    ack        = 1'b0;
    clr_cnt    = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_alarm();
    int n = 0;
    while (!alarm_active && n < 30) begin
      tick(1);
      n++;
    end
    check("alarm_wait", {31'd0, alarm_active}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; sensor = '0; mode_latch = 1'b0; ack = 1'b0; clr_cnt = 1'b0;
    #1;
    check("rst_buzzer", {28'd0, buzzer}, 32'd0);
    check("rst_active_ch", {30'd0, active_ch}, 32'd0);
    check("rst_alarm_active", {31'd0, alarm_active}, 32'd0);
    check("rst_event_cnt", {24'd0, event_cnt}, 32'd0);

    // Timed alarm on ch1, then requalification after cooldown.
    do_reset();
    sensor = 4'b0010;
    tick(7);
    check("s1_pre_buzzer", {28'd0, buzzer}, 32'h0);
    check("s1_qual_ch", {30'd0, active_ch}, 32'd1);
    tick(1);
    check("s1_buzzer_on", {28'd0, buzzer}, 32'h2);
    check("s1_alarm_active", {31'd0, alarm_active}, 32'd1);
    check("s1_event_cnt", {24'd0, event_cnt}, 32'd1);
    tick(31);
    check("s1_buzzer_last", {28'd0, buzzer}, 32'h2);
    tick(1);
    check("s1_buzzer_off", {28'd0, buzzer}, 32'h0);
    check("s1_alarm_off", {31'd0, alarm_active}, 32'd0);
    tick(11);
    check("s1_requal_pre", {28'd0, buzzer}, 32'h0);
    tick(1);
    check("s1_requal_on", {28'd0, buzzer}, 32'h2);
    check("s1_event_cnt2", {24'd0, event_cnt}, 32'd2);

    // Preemption by a higher-priority channel.
    do_reset();
    sensor = 4'b0100;
    tick(5);
    check("s2_qual_ch2", {30'd0, active_ch}, 32'd2);
    sensor = 4'b0110;
    tick(1);
    check("s2_preempt_ch", {30'd0, active_ch}, 32'd1);
    tick(6);
    check("s2_pre_buzzer", {28'd0, buzzer}, 32'h0);
    tick(1);
    check("s2_buzzer_ch1", {28'd0, buzzer}, 32'h2);

    // Glitch to zero at sample 7 aborts; a fresh qualification needs 8 samples.
    do_reset();
    sensor = 4'b0100;
    tick(6);
    sensor = 4'b0000;
    tick(1);
    check("s2g_no_alarm", {31'd0, alarm_active}, 32'd0);
    sensor = 4'b0100;
    tick(7);
    check("s2g_pre_buzzer", {28'd0, buzzer}, 32'h0);
    tick(1);
    check("s2g_buzzer", {28'd0, buzzer}, 32'h4);
    check("s2g_event_cnt", {24'd0, event_cnt}, 32'd1);

    // Latched alarm held past ALARM_LEN until ack; then timed alarm truncated by ack.
    do_reset();
    mode_latch = 1'b1;
    sensor = 4'b1000;
    tick(8);
    check("s3_buzzer_on", {28'd0, buzzer}, 32'h8);
    check("s3_active_ch", {30'd0, active_ch}, 32'd3);
    mode_latch = 1'b0;
    sensor = 4'b0000;
    tick(40);
    check("s3_latched_hold", {28'd0, buzzer}, 32'h8);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("s3_ack_buzzer", {28'd0, buzzer}, 32'h0);
    check("s3_ack_alarm", {31'd0, alarm_active}, 32'd0);
    check("s3_hold_ch", {30'd0, active_ch}, 32'd3);
    sensor = 4'b1000;
    tick(11);
    check("s3_cool_pre", {28'd0, buzzer}, 32'h0);
    tick(1);
    check("s3_realarm", {28'd0, buzzer}, 32'h8);
    sensor = 4'b0000;
    tick(9);
    check("s3_timed_mid", {28'd0, buzzer}, 32'h8);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("s3_timed_ack", {28'd0, buzzer}, 32'h0);

    // Enable low freezes the alarm timer and ignores ack.
    do_reset();
    sensor = 4'b0010;
    tick(8);
    sensor = 4'b0000;
    tick(10);
    ena = 1'b0;
    ack = 1'b1;
    sensor = 4'b0001;
    tick(20);
    check("s4_frozen_buzzer", {28'd0, buzzer}, 32'h2);
    check("s4_frozen_alarm", {31'd0, alarm_active}, 32'd1);
    check("s4_frozen_ch", {30'd0, active_ch}, 32'd1);
    ack = 1'b0;
    sensor = 4'b0000;
    ena = 1'b1;
    tick(21);
    check("s4_buzzer_last", {28'd0, buzzer}, 32'h2);
    tick(1);
    check("s4_buzzer_off", {28'd0, buzzer}, 32'h0);

    // Event counter saturation and clear-wins.
    do_reset();
    sensor = 4'b0001;
    for (int i = 0; i < 255; i++) begin
      wait_alarm();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
    end
    check("s5_cnt_255", {24'd0, event_cnt}, 32'd255);
    wait_alarm();
    check("s5_cnt_sat", {24'd0, event_cnt}, 32'd255);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(11);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    check("s5_clr_alarm", {31'd0, alarm_active}, 32'd1);
    check("s5_clr_wins", {24'd0, event_cnt}, 32'd0);

    // Asynchronous reset mid-QUALIFY and mid-ALARM.
    do_reset();
    sensor = 4'b0010;
    tick(4);
    check("s6_qual_ch", {30'd0, active_ch}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rstq_ch", {30'd0, active_ch}, 32'd0);
    #2 rst_n = 1'b1;
    tick(7);
    check("s6_full_pre", {28'd0, buzzer}, 32'h0);
    tick(1);
    check("s6_full_on", {28'd0, buzzer}, 32'h2);
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rsta_buzzer", {28'd0, buzzer}, 32'h0);
    check("s6_rsta_alarm", {31'd0, alarm_active}, 32'd0);
    check("s6_rsta_cnt", {24'd0, event_cnt}, 32'd0);
    check("s6_rsta_ch", {30'd0, active_ch}, 32'd0);
    #2 rst_n = 1'b1;
    tick(7);
    check("s6_re_pre", {28'd0, buzzer}, 32'h0);
    tick(1);
    check("s6_re_on", {28'd0, buzzer}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
